// File: rtl/sha_apb_pkg.sv
// Shared definitions for the two-requester APB arbiter/sequencer.
//   state_t     : sequencer states (IDLE, SETUP, ACCESS)
//   NREQ        : number of requesters sharing the APB port
//   DEF_ADDR_W  : default APB address width
//   DEF_DATA_W  : default APB data width
package sha_apb_pkg;

    localparam int NREQ       = 2;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

endpackage

// File: rtl/sha_apb_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant.
//   req_valid : per-requester request
//   last      : index of the requester served most recently
//   grant_vld : at least one requester is asking
//   grant_idx : index of the granted requester (meaningful when grant_vld)
module rr_arb2
    import sha_apb_pkg::*;
(
    input  logic [NREQ-1:0] req_valid,
    input  logic            last,
    output logic            grant_vld,
    output logic            grant_idx
);

    always_comb begin
        grant_vld = |req_valid;
        // On a tie the requester not served last wins; otherwise the sole
        // active requester is granted (bit 1 set means requester 1).
        if (&req_valid) begin
            grant_idx = ~last;
        end else begin
            grant_idx = req_valid[1];
        end
    end

endmodule

// File: rtl/sha_apb_arbiter.sv
// APB master-side arbiter and sequencer sharing one APB slave port between
// two requesters. Each requester issues single-word commands over
// valid/ready; the block round-robins between them, runs SETUP/ACCESS, and
// returns a one-cycle response pulse with read data and error status.
// A PREADY timeout (TIMEOUT ACCESS cycles with PREADY low, 0 = disabled)
// aborts hung transfers with an error.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/ready/write    : per-requester command handshake and direction
//   req_addr, req_wdata      : requester i in slice [i*W +: W]
//   rsp_valid                : one-cycle response pulse per requester
//   rsp_rdata, rsp_err       : shared response data/error, qualified by rsp_valid
//   PADDR..PENABLE           : APB master outputs
//   PRDATA, PREADY, PSLVERR  : APB slave responses
module sha_apb_arbiter
    import sha_apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_write,
    input  logic [2*ADDR_W-1:0]    req_addr,
    input  logic [2*DATA_W-1:0]    req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      PADDR,
    output logic [DATA_W-1:0]      PWDATA,
    output logic                   PWRITE,
    output logic                   PSEL,
    output logic                   PENABLE,
    input  logic [DATA_W-1:0]      PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    // A disabled timeout still needs a legal one-bit counter.
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam bit              TO_EN   = (TIMEOUT != 0);

    state_t            state;
    state_t            next_state;
    logic              last;
    logic              grant_vld;
    logic              grant_idx;
    logic              handshake;
    logic              done;
    logic              abort;
    logic              owner;
    logic [CNT_W-1:0]  cnt;

    rr_arb2 u_arb (
        .req_valid (req_valid),
        .last      (last),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // PSEL/PENABLE decode straight from the state register so an
    // asynchronous reset drops them without waiting for a clock edge.
    // req_ready is additionally masked by rst so every output reads 0
    // while reset is held.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        handshake  = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    handshake            = 1'b1;
                    next_state           = SETUP;
                end
            end
            SETUP: begin
                PSEL       = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                // A slave completing in the same cycle the budget runs out
                // still wins over the abort.
                if (PREADY) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if (TO_EN && (cnt == CNT_MAX)) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Wait-state counter: cleared when a command is accepted, counts
    // PREADY-low ACCESS cycles and stops at the abort threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (handshake) begin
            cnt <= '0;
        end else if (TO_EN && (state == ACCESS) && !PREADY && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (handshake) begin
            last <= grant_idx;
        end
    end

    // Command latch; the APB address/data/direction hold their last value
    // between transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            owner  <= 1'b0;
        end else if (handshake) begin
            PADDR  <= grant_idx ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
            PWDATA <= grant_idx ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
            PWRITE <= grant_idx ? req_write[1]                  : req_write[0];
            owner  <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (done) begin
                rsp_valid[owner] <= 1'b1;
                rsp_rdata        <= PWRITE ? '0 : PRDATA;
                rsp_err          <= PSLVERR;
            end else if (abort) begin
                rsp_valid[owner] <= 1'b1;
                rsp_err          <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sha_apb_arbiter.sv
// Randomized bench for sha_apb_arbiter. The reference model is transaction
// level: each accepted command is scheduled with its handshake cycle and a
// chosen wait count, and every cycle's expected APB phase, response and
// grant are derived arithmetically from that schedule.
module tb_sha_apb_arbiter;

    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int TO     = 4;
    localparam int NCYC   = 3000;
    localparam int RST_AT = 1500;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_write;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [1:0]        rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DW-1:0]     PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    always #5 clk = ~clk;

    sha_apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester-side pending commands
    bit [1:0]        pv;
    bit [1:0]        pw;
    logic [AW-1:0]   pa [2];
    logic [DW-1:0]   pd [2];

    // Model of the single in-flight transfer
    bit              t_act;
    int              t_h, t_w, t_end;
    bit              t_g, t_wr, t_to;
    logic [AW-1:0]   t_a;
    logic [DW-1:0]   t_d;
    logic [DW-1:0]   t_rd;
    bit              t_err;

    bit              m_last;
    bit              hs;
    bit              hs_g;
    bit              did_rst;
    bit              first_txn;
    int              cyc;

    initial begin
        bit        in_setup, in_acc, busy, g;
        logic [1:0] exp_rv, exp_rdy;

        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        pv = '0; pw = '0; t_act = 0; hs = 0; did_rst = 0; first_txn = 1; cyc = 0;
        m_last = 1'b1;

        #2;
        check_eq("rst_req_ready", req_ready, 2'b00);
        check_eq("rst_rsp_valid", rsp_valid, 2'b00);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_rsp_err",   rsp_err,   0);
        check_eq("rst_paddr",     PADDR,     0);
        check_eq("rst_pwdata",    PWDATA,    0);
        check_eq("rst_pwrite",    PWRITE,    0);
        check_eq("rst_psel",      PSEL,      0);
        check_eq("rst_penable",   PENABLE,   0);
        @(posedge clk);

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            if (rst) begin
                // Reset release: arbiter history and in-flight transfer are gone;
                // present a tie so the post-reset priority is exercised.
                rst    = 1'b0;
                m_last = 1'b1;
                t_act  = 0;
                hs     = 0;
                for (int r = 0; r < 2; r++) begin
                    if (!pv[r]) begin
                        pv[r] = 1; pw[r] = 1'($urandom);
                        pa[r] = AW'($urandom); pd[r] = $urandom;
                    end
                end
            end
            if (hs) begin
                pv[hs_g] = 0;
                hs = 0;
            end
            for (int r = 0; r < 2; r++) begin
                if (!pv[r]) begin
                    if ($urandom_range(99) < 60) begin
                        pv[r] = 1; pw[r] = 1'($urandom);
                        pa[r] = AW'($urandom); pd[r] = $urandom;
                    end
                end else if ($urandom_range(99) < 3) begin
                    pv[r] = 0;
                end
            end
            if (n == 0) begin
                pv = 2'b01; pw[0] = 1; pa[0] = 12'h010; pd[0] = 32'hDEADBEEF;
            end
            req_valid = pv;
            req_write = pw;
            req_addr  = {pa[1], pa[0]};
            req_wdata = {pd[1], pd[0]};

            in_acc   = t_act && (cyc >= t_h + 2) && (cyc <= t_end);
            in_setup = t_act && (cyc == t_h + 1);
            PRDATA   = $urandom;
            PSLVERR  = ($urandom_range(3) == 0);
            if (in_acc) begin
                PREADY = (cyc == t_h + 2 + t_w);
                if (PREADY) begin
                    t_rd  = t_wr ? '0 : PRDATA;
                    t_err = PSLVERR;
                end
            end else begin
                PREADY = 1'($urandom);
            end

            if (n >= RST_AT && !did_rst && in_acc) begin
                #2 rst = 1'b1;
                #1;
                check_eq("arst_psel",      PSEL,      0);
                check_eq("arst_penable",   PENABLE,   0);
                check_eq("arst_rsp_valid", rsp_valid, 2'b00);
                check_eq("arst_req_ready", req_ready, 2'b00);
                did_rst = 1;
                @(negedge clk);
                check_eq("arst_hold_psel", PSEL, 0);
                cyc++;
                continue;
            end

            @(negedge clk);
            check_eq("psel",    PSEL,    in_setup || in_acc);
            check_eq("penable", PENABLE, in_acc);
            if (in_setup || in_acc) begin
                check_eq("paddr",  PADDR,  t_a);
                check_eq("pwrite", PWRITE, t_wr);
                check_eq("pwdata", PWDATA, t_d);
            end

            exp_rv = (t_act && cyc == t_end + 1) ? (2'b01 << t_g) : 2'b00;
            check_eq("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != 2'b00) begin
                check_eq(t_to ? "rsp_rdata_to" : "rsp_rdata", rsp_rdata, t_rd);
                check_eq(t_to ? "rsp_err_to"   : "rsp_err",   rsp_err,   t_err);
            end

            busy = t_act && (cyc <= t_end);
            g    = (pv == 2'b11) ? ~m_last : pv[1];
            exp_rdy = (busy || pv == 2'b00) ? 2'b00 : (2'b01 << g);
            check_eq("req_ready", req_ready, exp_rdy);

            if (!busy && pv != 2'b00) begin
                hs     = 1;
                hs_g   = g;
                m_last = g;
                t_act  = 1;
                t_h    = cyc;
                t_g    = g;
                t_wr   = pw[g];
                t_a    = pa[g];
                t_d    = pd[g];
                if (first_txn) begin
                    t_w = 0;
                    first_txn = 0;
                end else if ($urandom_range(9) == 0) begin
                    t_w = TO + 1 + $urandom_range(3);
                end else begin
                    t_w = $urandom_range(TO);
                end
                t_to  = (t_w > TO);
                t_end = t_h + 2 + (t_to ? TO : t_w);
                if (t_to) begin
                    t_rd  = '0;
                    t_err = 1;
                end
            end
            cyc++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
